// File: rtl/vg_vector_integrator.sv
// Vector integrator: steps beam X/Y with 12-bit binary-rate-multiplier accumulators
// over a draw window of 4096 >> norm_shift cycles, then pulses done.
module vg_vector_integrator (
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic [12:0] DVX,
    input  logic [12:0] DVY,
    input  logic [2:0]  Z,
    input  logic [3:0]  norm_shift,
    input  logic        go,
    input  logic        center,
    output logic [11:0] X_pos,
    output logic [11:0] Y_pos,
    output logic [2:0]  beam_z,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t      r_state;
    logic        r_sign_x, r_sign_y;
    logic [11:0] r_mag_x, r_mag_y;
    logic [11:0] r_acc_x, r_acc_y;
    logic [12:0] r_cnt;
    logic [11:0] r_x, r_y;
    logic [2:0]  r_z;
    logic        r_busy, r_done;

    // |dv| in 13 bits; only -4096 overflows 12 bits and saturates to 4095
    function automatic logic [11:0] f_mag(input logic [12:0] dv);
        logic [12:0] n;
        n = dv[12] ? (~dv + 13'd1) : dv;
        return n[12] ? 12'hFFF : n[11:0];
    endfunction

    logic [3:0]  w_shift;
    logic [12:0] w_steps;
    logic [12:0] w_sum_x, w_sum_y;
    logic [11:0] w_dx, w_dy;

    assign w_shift = (norm_shift > 4'd12) ? 4'd12 : norm_shift;
    assign w_steps = 13'h1000 >> w_shift;
    assign w_sum_x = {1'b0, r_acc_x} + {1'b0, r_mag_x};
    assign w_sum_y = {1'b0, r_acc_y} + {1'b0, r_mag_y};
    assign w_dx    = r_sign_x ? 12'hFFF : 12'h001;
    assign w_dy    = r_sign_y ? 12'hFFF : 12'h001;

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sign_x <= 1'b0;
            r_sign_y <= 1'b0;
            r_mag_x  <= '0;
            r_mag_y  <= '0;
            r_acc_x  <= '0;
            r_acc_y  <= '0;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_sign_x <= DVX[12];
                        r_sign_y <= DVY[12];
                        r_mag_x  <= f_mag(DVX);
                        r_mag_y  <= f_mag(DVY);
                        r_acc_x  <= 12'h800;
                        r_acc_y  <= 12'h800;
                        r_cnt    <= w_steps;
                        r_z      <= Z;
                        r_busy   <= 1'b1;
                        r_state  <= S_DRAW;
                    end else if (center) begin
                        r_x <= '0;
                        r_y <= '0;
                    end
                end
                S_DRAW: begin
                    r_acc_x <= w_sum_x[11:0];
                    r_acc_y <= w_sum_y[11:0];
                    if (w_sum_x[12]) r_x <= r_x + w_dx;
                    if (w_sum_y[12]) r_y <= r_y + w_dy;
                    r_cnt <= r_cnt - 13'd1;
                    // last accumulation of the window happens on this edge
                    if (r_cnt == 13'd1) begin
                        r_busy  <= 1'b0;
                        r_z     <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign X_pos  = r_x;
    assign Y_pos  = r_y;
    assign beam_z = r_z;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
